fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Decoupling buffer between the instruction fetch stage and the instruction decode stage. It holds up to DEPTH fetched {pc, instruction} pairs in a circular FIFO, and hands them to decode over a valid/ready handshake. On a branch redirect it flushes its contents and discards the stale in-flight fetches that the synchronous instruction memory still returns.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_W, 32, PC width
INSTR_W, 32, instruction width
FLUSH_DROP, 1, number of accepted input beats to discard after a flush (instruction memory read latency)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high
in_valid  in  1  fetch stage presents a beat
in_ready  out  1  queue accepts the beat this cycle
in_pc  in  ADDR_W  PC of the fetched instruction
in_instr  in  INSTR_W  fetched instruction word
flush  in  1  branch redirect from decode/execute; single-cycle pulse
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode consumes the head entry
out_pc  out  ADDR_W  PC of the head entry
out_instr  out  INSTR_W  instruction word of the head entry
count  out  clog2(DEPTH+1)  current occupancy
dropping  out  1  high while stale post-flush beats are being discarded

Behaviour:
- Reset (asynchronous, active-high, reset on clk):
  - count=0; rd_ptr=wr_ptr=0; state=RUN; drop_cnt=0.
  - Outputs during and after reset: out_valid=0, in_ready=1, dropping=0, out_pc=0, out_instr=0.
  - Reset mid-operation discards all entries immediately.
- Storage and pointers:
  - DEPTH entries of {pc, instr}.
  - wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - Entry contents are not reset.
- First-word-fall-through read:
  - out_pc and out_instr equal the entry at rd_ptr when count!=0.
  - When count==0 they are forced to 0.
- Handshake signals:
  - out_valid = (count!=0) && !flush.
  - in_ready = (state==DROP) || (count!=DEPTH). in_ready has no combinational path from out_ready.
  - push = in_valid && in_ready && state==RUN && !flush.
  - pop = out_valid && out_ready.
- Latency and occupancy:
  - A beat pushed in cycle N is visible on out_* in cycle N+1. There is no same-cycle bypass.
  - Push and pop together: count is unchanged and both pointers advance.
  - Full (count==DEPTH): in_ready=0; a pop that cycle frees a slot for cycle N+1 only.
  - Empty: out_valid=0. Zero-beat gaps are allowed.
- State machine (2 states):
  - RUN: normal push and pop.
  - DROP: in_ready=1 and dropping=1. Every beat with in_valid is accepted and discarded, decrementing drop_cnt. When a beat is discarded with drop_cnt==1, the next state is RUN.
- Flush, which has priority over everything except reset:
  - Next cycle: count=0, ptrs=0, drop_cnt=FLUSH_DROP.
  - State becomes DROP if FLUSH_DROP>0, else RUN.
  - A push or pop in the flush cycle is ignored; out_valid is already 0 in that cycle.
  - A flush while in DROP reloads drop_cnt.
  - A flush on an empty queue behaves identically.
- count saturates by construction: no overflow and no underflow. in_valid while full, or out_ready while empty, has no effect.

Decomposition:
- Shared package fetch_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - fq_state_t enum {RUN, DROP}.
  - fetch_entry_t struct {pc, instr}, reused by the decode stage.
- One sub-module, fetch_queue_ram:
  - DEPTH x entry register array.
  - Synchronous write port and asynchronous read port.
  - Control, pointers, counter and FSM stay in fetch_queue.

Test Plan:
1. Reset, then push pc=0x0/instr=0x11111111 with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x11111111, count=1.
2. Push 4 beats (pc 0x0..0xC) with out_ready=0 -> count=4 and in_ready=0. A fifth beat (pc 0x10) is held. Then pop with out_ready=1 -> outputs appear in order 0x0, 0x4, 0x8, 0xC, 0x10, and count never exceeds 4.
3. Continuous in_valid=1 and out_ready=1 for 20 cycles, pc incrementing by 4 -> count stays 1, in-order output with no loss, and pointers wrap at least 4 times.
4. Queue holds 3 entries; flush pulse -> out_valid=0 in the flush cycle. Next cycle count=0 and dropping=1. The next in beat (pc 0x8) is discarded and dropping returns to 0. The following beat (pc 0x40) appears at out_pc.
5. Flush asserted again while dropping=1 -> drop_cnt reloads, so exactly FLUSH_DROP further beats are discarded after the second flush.
6. Assert reset asynchronously mid-stream with 2 entries held -> out_valid=0, count=0 and in_ready=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side types: default widths, fetch queue state and the
// {pc, instr} entry that also travels into the decode stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;

  typedef enum logic {
    RUN,
    DROP
  } fq_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port so the head entry falls straight through to decode.
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with branch-redirect flush and discard of
// the stale beats still returning from the synchronous instruction memory.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = FETCH_ADDR_W,
  parameter int INSTR_W    = FETCH_INSTR_W,
  parameter int FLUSH_DROP = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       dropping
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int DROP_W  = (FLUSH_DROP < 1) ? 1 : $clog2(FLUSH_DROP + 1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fq_state_t          state;
  logic [DROP_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ENTRY_W-1:0] head;
  logic               empty;
  logic               push;
  logic               pop;
  logic               discard;

  // in_ready depends only on registered state, never on out_ready.
  assign empty     = (count == '0);
  assign in_ready  = (state == DROP) || (count != CNT_W'(DEPTH));
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready && (state == RUN) && !flush;
  assign pop       = out_valid && out_ready;
  assign discard   = in_valid && (state == DROP);
  assign dropping  = (state == DROP);
  assign out_pc    = empty ? '0 : head[ENTRY_W-1 -: ADDR_W];
  assign out_instr = empty ? '0 : head[INSTR_W-1:0];

  fetch_queue_ram #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata({in_pc, in_instr}),
    .raddr(rd_ptr),
    .rdata(head)
  );

  // Flush wins over push/pop/discard; a flush in DROP simply reloads the drop budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (flush) begin
      state    <= (FLUSH_DROP > 0) ? DROP : RUN;
      drop_cnt <= DROP_W'(FLUSH_DROP);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (discard) begin
        drop_cnt <= drop_cnt - DROP_W'(1);
        if (drop_cnt == DROP_W'(1)) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;

  localparam int DEPTH      = 4;
  localparam int FLUSH_DROP = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        dropping;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] mq[$];
  int          m_drop_left = 0;
  bit          m_dropping = 1'b0;

  fetch_queue #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .INSTR_W(32),
    .FLUSH_DROP(FLUSH_DROP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .count(count),
    .dropping(dropping)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                input logic fl, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    flush     = fl;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of {pc, instr} plus a count of beats left to discard.
  always @(posedge clk or posedge reset) begin : model
    bit rdy;
    bit vld;
    if (reset) begin
      mq.delete();
      m_drop_left = 0;
      m_dropping  = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_drop_left = FLUSH_DROP;
      m_dropping  = (FLUSH_DROP > 0);
    end else begin
      rdy = m_dropping || (mq.size() < DEPTH);
      vld = (mq.size() != 0);
      if (vld && out_ready) void'(mq.pop_front());
      if (m_dropping) begin
        if (in_valid) begin
          m_drop_left--;
          if (m_drop_left == 0) m_dropping = 1'b0;
        end
      end else if (in_valid && rdy) begin
        mq.push_back({in_pc, in_instr});
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [63:0] hd;
    int sz;
    sz = mq.size();
    hd = (sz != 0) ? mq[0] : 64'h0;
    check_output("cyc_out_valid", {63'h0, out_valid}, {63'h0, (sz != 0) && !flush});
    check_output("cyc_in_ready", {63'h0, in_ready}, {63'h0, m_dropping || (sz < DEPTH)});
    check_output("cyc_dropping", {63'h0, dropping}, {63'h0, m_dropping});
    check_output("cyc_count", {61'h0, count}, 64'(sz));
    check_output("cyc_out_entry", {out_pc, out_instr}, hd);
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_order[5];
    int          max_cnt;
    bit          sent;

    exp_order[0] = 32'h0;
    exp_order[1] = 32'h4;
    exp_order[2] = 32'h8;
    exp_order[3] = 32'hC;
    exp_order[4] = 32'h10;

    #3;
    check_output("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check_output("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check_output("rst_dropping", {63'h0, dropping}, 64'h0);
    check_output("rst_count", {61'h0, count}, 64'h0);
    check_output("rst_out_pc", {32'h0, out_pc}, 64'h0);
    @(posedge clk);
    step();
    reset = 1'b0;

    // Single beat with decode stalled.
    apply_stimulus(1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("t1_out_valid", {63'h0, out_valid}, 64'h1);
    check_output("t1_out_pc", {32'h0, out_pc}, 64'h0);
    check_output("t1_out_instr", {32'h0, out_instr}, 64'h11111111);
    check_output("t1_count", {61'h0, count}, 64'h1);
    out_ready = 1'b1;
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill to full, hold a fifth beat, then drain in order.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'(i * 4), 32'hA0000000 | 32'(i), 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b1, 32'h10, 32'hA0000010, 1'b0, 1'b0);
    #1;
    check_output("t2_full_count", {61'h0, count}, 64'h4);
    check_output("t2_full_in_ready", {63'h0, in_ready}, 64'h0);
    out_ready = 1'b1;
    max_cnt = 0;
    got.delete();
    for (int k = 0; k < 12 && got.size() < 5; k++) begin
      #1;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (out_valid) got.push_back(out_pc);
      sent = in_valid && in_ready;
      step();
      if (sent) in_valid = 1'b0;
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_output("t2_num_out", 64'(got.size()), 64'h5);
    for (int i = 0; i < got.size() && i < 5; i++)
      check_output("t2_order", {32'h0, got[i]}, {32'h0, exp_order[i]});
    check_output("t2_max_count", 64'(max_cnt), 64'h4);

    // Streaming: occupancy settles at one, pointers wrap repeatedly.
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, 32'h100 + 32'(4 * k), 32'hB0000000 | 32'(k), 1'b0, 1'b1);
      #1;
      if (k > 0) begin
        check_output("t3_count", {61'h0, count}, 64'h1);
        check_output("t3_out_pc", {32'h0, out_pc}, {32'h0, 32'h100 + 32'(4 * (k - 1))});
      end
      step();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with three entries held, then one stale beat is discarded.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h200 + 32'(4 * i), 32'hC0000000 | 32'(i), 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check_output("t4_flush_out_valid", {63'h0, out_valid}, 64'h0);
    step();
    apply_stimulus(1'b1, 32'h8, 32'hDEAD0008, 1'b0, 1'b0);
    #1;
    check_output("t4_count", {61'h0, count}, 64'h0);
    check_output("t4_dropping", {63'h0, dropping}, 64'h1);
    step();
    apply_stimulus(1'b1, 32'h40, 32'h40404040, 1'b0, 1'b0);
    #1;
    check_output("t4_drop_done", {63'h0, dropping}, 64'h0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("t4_out_valid", {63'h0, out_valid}, 64'h1);
    check_output("t4_out_pc", {32'h0, out_pc}, 64'h40);
    check_output("t4_out_count", {61'h0, count}, 64'h1);

    // Second flush arrives together with a stale beat while already dropping.
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h44, 32'h44444444, 1'b1, 1'b0);
    #1;
    check_output("t5_dropping_a", {63'h0, dropping}, 64'h1);
    step();
    apply_stimulus(1'b1, 32'h50, 32'h50505050, 1'b0, 1'b0);
    #1;
    check_output("t5_dropping_b", {63'h0, dropping}, 64'h1);
    step();
    apply_stimulus(1'b1, 32'h60, 32'h60606060, 1'b0, 1'b0);
    #1;
    check_output("t5_dropping_c", {63'h0, dropping}, 64'h0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_output("t5_out_pc", {32'h0, out_pc}, 64'h60);
    check_output("t5_count", {61'h0, count}, 64'h1);
    out_ready = 1'b1;
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset with two entries held.
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 32'h300 + 32'(4 * i), 32'hD0000000 | 32'(i), 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_output("t6_out_valid", {63'h0, out_valid}, 64'h0);
    check_output("t6_count", {61'h0, count}, 64'h0);
    check_output("t6_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    reset = 1'b0;

    // Randomized traffic with a varying mix of stalls and redirects.
    for (int blk = 0; blk < 6; blk++) begin
      int vbias;
      int rbias;
      vbias = $urandom_range(1, 4);
      rbias = $urandom_range(0, 3);
      for (int k = 0; k < 100; k++) begin
        apply_stimulus($urandom_range(0, 4) < vbias, $urandom, $urandom,
                       $urandom_range(0, 24) == 0, $urandom_range(0, 3) < rbias);
        step();
      end
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
